// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types, digit limits and prescaler sizing for the stopwatch
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  // Prescaler needs at least one bit even when every tick is a full second.
  function automatic int presc_width(input int ticks);
    int w;
    w = $clog2(ticks);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// rtl/bcd_digit_cnt.sv - single BCD digit counter with programmable wrap value and carry
module bcd_digit_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [3:0] wrap_val,
  output logic [3:0] digit,
  output logic       carry
);

  assign carry = en & (digit == wrap_val);

  // Clear beats counting so a rollover or user clear always lands on zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit <= 4'd0;
    end else if (clr) begin
      digit <= 4'd0;
    end else if (en) begin
      if (carry) begin
        digit <= 4'd0;
      end else begin
        digit <= digit + 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_stopwatch.sv
// rtl/bcd_stopwatch.sv - MM:SS BCD stopwatch driven by a tick enable in the sys_clk domain
module bcd_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1,
  parameter int MIN_WRAP      = 60
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       tick_in,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       wrap_pulse
);

  localparam int              PW            = presc_width(TICKS_PER_SEC);
  localparam logic [PW-1:0]   PRESC_LAST    = PW'(TICKS_PER_SEC - 1);
  localparam logic [3:0]      MIN_LAST_ONES = 4'((MIN_WRAP - 1) % 10);
  localparam logic [3:0]      MIN_LAST_TENS = 4'((MIN_WRAP - 1) / 10);

  sw_state_t     state_q;
  sw_state_t     state_d;
  logic          tick_d;
  logic          rise;
  logic [PW-1:0] presc_q;
  logic          count_en;
  logic          sec_step;
  logic          so_c;
  logic          st_c;
  logic          mo_c;
  logic          mt_c;
  logic          min_at_last;
  logic          rollover;
  logic          digits_clr;

  assign rise     = tick_in & ~tick_d;
  // Decisions use the current state, so a rise on the pause command still
  // counts while a rise on the resume command does not.
  assign count_en = (state_q == RUN) & rise & ~clear;
  assign sec_step = count_en & (presc_q == PRESC_LAST);

  assign min_at_last = (min_ones == MIN_LAST_ONES) & (min_tens == MIN_LAST_TENS);
  // min_tens can only overflow at 99:59, which is already the last minute when
  // MIN_WRAP is 100; folding it in keeps the digits from ever passing 99.
  assign rollover    = (st_c & min_at_last) | mt_c;
  assign digits_clr  = clear | rollover;

  assign running = (state_q == RUN);

  // Registered copy of tick_in for rising-edge detection.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      tick_d <= 1'b0;
    end else begin
      tick_d <= tick_in;
    end
  end

  // Run/pause state register.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: clear dominates, start_stop toggles between running and held.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (start_stop) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Prescaler counts rises within a second and is held while paused.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      presc_q <= '0;
    end else if (clear) begin
      presc_q <= '0;
    end else if (count_en) begin
      if (presc_q == PRESC_LAST) begin
        presc_q <= '0;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
    end
  end

  // Full-scale rollover flag, high for the single cycle the digits return to zero.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= rollover;
    end
  end

  bcd_digit_cnt u_sec_ones (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .clr      (digits_clr),
    .en       (sec_step),
    .wrap_val (BCD_MAX),
    .digit    (sec_ones),
    .carry    (so_c)
  );

  bcd_digit_cnt u_sec_tens (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .clr      (digits_clr),
    .en       (so_c),
    .wrap_val (SEC_TENS_MAX),
    .digit    (sec_tens),
    .carry    (st_c)
  );

  bcd_digit_cnt u_min_ones (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .clr      (digits_clr),
    .en       (st_c),
    .wrap_val (BCD_MAX),
    .digit    (min_ones),
    .carry    (mo_c)
  );

  bcd_digit_cnt u_min_tens (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .clr      (digits_clr),
    .en       (mo_c),
    .wrap_val (BCD_MAX),
    .digit    (min_tens),
    .carry    (mt_c)
  );

endmodule

// File: tb/tb_bcd_stopwatch.sv
// tb/tb_bcd_stopwatch.sv - randomized self-checking bench for bcd_stopwatch against a seconds-count model
module tb_bcd_stopwatch;

  localparam int MIN_WRAP = 60;
  localparam int FULL_SEC = MIN_WRAP * 60;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic tick_in = 1'b0;
  logic start_stop = 1'b0;
  logic clear = 1'b0;

  logic [15:0] bcd0;
  logic [15:0] bcd1;
  logic [1:0]  run_o;
  logic [1:0]  wrap_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  // reference model: elapsed seconds as a plain integer, per instance
  int   m_secs [2];
  int   m_presc [2];
  bit   m_run [2];
  bit   m_wrap [2];
  bit   m_tick_prev;
  int   mism [2];
  int   wraps_dut [2];
  int   wraps_ref [2];

  always #5 sys_clk = ~sys_clk;

  bcd_stopwatch #(.TICKS_PER_SEC(1), .MIN_WRAP(MIN_WRAP)) dut0 (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .tick_in    (tick_in),
    .start_stop (start_stop),
    .clear      (clear),
    .sec_ones   (bcd0[3:0]),
    .sec_tens   (bcd0[7:4]),
    .min_ones   (bcd0[11:8]),
    .min_tens   (bcd0[15:12]),
    .running    (run_o[0]),
    .wrap_pulse (wrap_o[0])
  );

  bcd_stopwatch #(.TICKS_PER_SEC(3), .MIN_WRAP(MIN_WRAP)) dut1 (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .tick_in    (tick_in),
    .start_stop (start_stop),
    .clear      (clear),
    .sec_ones   (bcd1[3:0]),
    .sec_tens   (bcd1[7:4]),
    .min_ones   (bcd1[11:8]),
    .min_tens   (bcd1[15:12]),
    .running    (run_o[1]),
    .wrap_pulse (wrap_o[1])
  );

  function automatic logic [15:0] exp_bcd(input int secs);
    int mm;
    int ss;
    mm = secs / 60;
    ss = secs % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [15:0] obs_bcd(input int k);
    return (k == 0) ? bcd0 : bcd1;
  endfunction

  task automatic model_edge(input logic rn, input logic t, input logic ss, input logic cl);
    bit r;
    r = t && !m_tick_prev;
    for (int k = 0; k < 2; k++) begin
      if (!rn) begin
        m_run[k] = 0; m_presc[k] = 0; m_secs[k] = 0; m_wrap[k] = 0;
      end else begin
        m_wrap[k] = 0;
        if (cl) begin
          m_run[k] = 0; m_presc[k] = 0; m_secs[k] = 0;
        end else begin
          if (m_run[k] && r) begin
            m_presc[k]++;
            if (m_presc[k] == ((k == 0) ? 1 : 3)) begin
              m_presc[k] = 0;
              m_secs[k]++;
              if (m_secs[k] == FULL_SEC) begin
                m_secs[k] = 0;
                m_wrap[k] = 1;
              end
            end
          end
          if (ss) m_run[k] = !m_run[k];
        end
      end
    end
    m_tick_prev = rn ? t : 1'b0;
  endtask

  // one sys_clk cycle: drive, let the edge happen, record observations
  task automatic step(input logic rn, input logic t, input logic ss, input logic cl);
    sys_rst_n = rn; tick_in = t; start_stop = ss; clear = cl;
    @(posedge sys_clk);
    model_edge(rn, t, ss, cl);
    @(negedge sys_clk);
    for (int k = 0; k < 2; k++) begin
      if (obs_bcd(k) !== exp_bcd(m_secs[k]) || run_o[k] !== m_run[k] || wrap_o[k] !== m_wrap[k])
        mism[k]++;
      wraps_dut[k] += int'(wrap_o[k] === 1'b1);
      wraps_ref[k] += int'(m_wrap[k]);
    end
  endtask

  task automatic rise(input int hi, input int lo);
    repeat (hi) step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (lo) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (m_secs[0] != target && guard < 5000) begin
      rise($urandom_range(1, 2), $urandom_range(1, 3));
      guard++;
    end
    if (m_secs[0] != target) begin
      total_cnt++;
      $display("FAIL run_to_bound target=%0d reached=%0d", target, m_secs[0]);
    end
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      total_cnt++;
      if (obs_bcd(k) !== 16'h0000 || run_o[k] !== 1'b0 || wrap_o[k] !== 1'b0)
        $display("FAIL reset dut%0d got bcd=%h run=%b wrap=%b want 0000/0/0", k, obs_bcd(k), run_o[k], wrap_o[k]);
      else pass_cnt++;
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_start_count();
    int bad;
    bad = 0;
    step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      if (bcd0 !== exp_bcd(i + 1)) bad++;
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
    end
    total_cnt++;
    if (bad !== 0) $display("FAIL start_latency got %0d late updates want 0", bad);
    else pass_cnt++;
    total_cnt++;
    if (bcd0 !== 16'h0012 || run_o[0] !== 1'b1)
      $display("FAIL start_12 got bcd=%h run=%b want 0012/1", bcd0, run_o[0]);
    else pass_cnt++;
    total_cnt++;
    if (bcd1 !== 16'h0004) $display("FAIL start_presc3 got %h want 0004", bcd1);
    else pass_cnt++;
  endtask

  task automatic test_carry();
    run_to(59);
    rise(1, 1);
    total_cnt++;
    if (bcd0 !== 16'h0100) $display("FAIL carry_0100 got %h want 0100", bcd0);
    else pass_cnt++;
    wraps_dut[0] = 0;
    run_to(9 * 60 + 59);
    rise(1, 1);
    total_cnt++;
    if (bcd0 !== 16'h1000 || wraps_dut[0] !== 0)
      $display("FAIL carry_1000 got bcd=%h wraps=%0d want 1000/0", bcd0, wraps_dut[0]);
    else pass_cnt++;
  endtask

  task automatic test_rollover();
    run_to(FULL_SEC - 1);
    total_cnt++;
    if (bcd0 !== 16'h5959) $display("FAIL roll_pre got %h want 5959", bcd0);
    else pass_cnt++;
    wraps_dut[0] = 0;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    total_cnt++;
    if (bcd0 !== 16'h0000 || wrap_o[0] !== 1'b1 || run_o[0] !== 1'b1)
      $display("FAIL roll_edge got bcd=%h wrap=%b run=%b want 0000/1/1", bcd0, wrap_o[0], run_o[0]);
    else pass_cnt++;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (wraps_dut[0] !== 1 || run_o[0] !== 1'b1)
      $display("FAIL roll_width got wrap_cycles=%0d run=%b want 1/1", wraps_dut[0], run_o[0]);
    else pass_cnt++;
  endtask

  task automatic test_pause_prescale();
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    rise(2, 2);
    rise(2, 2);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (5) rise(2, 2);
    total_cnt++;
    if (bcd1 !== 16'h0000 || run_o[1] !== 1'b0 || bcd0 !== 16'h0002)
      $display("FAIL pause_hold got bcd1=%h run1=%b bcd0=%h want 0000/0/0002", bcd1, run_o[1], bcd0);
    else pass_cnt++;
    step(1'b1, 1'b0, 1'b1, 1'b0);
    rise(2, 2);
    total_cnt++;
    if (bcd1 !== 16'h0001 || run_o[1] !== 1'b1 || bcd0 !== 16'h0003)
      $display("FAIL pause_resume got bcd1=%h run1=%b bcd0=%h want 0001/1/0003", bcd1, run_o[1], bcd0);
    else pass_cnt++;
  endtask

  task automatic test_same_cycle();
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (bcd0 !== 16'h0001 || run_o[0] !== 1'b0)
      $display("FAIL pause_rise got bcd=%h run=%b want 0001/0", bcd0, run_o[0]);
    else pass_cnt++;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (bcd0 !== 16'h0001 || run_o[0] !== 1'b1)
      $display("FAIL resume_rise got bcd=%h run=%b want 0001/1", bcd0, run_o[0]);
    else pass_cnt++;
  endtask

  task automatic test_clear_priority();
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (7) rise(1, 1);
    total_cnt++;
    if (bcd0 !== 16'h0007) $display("FAIL clear_pre got %h want 0007", bcd0);
    else pass_cnt++;
    step(1'b1, 1'b0, 1'b1, 1'b1);
    total_cnt++;
    if (bcd0 !== 16'h0000 || run_o[0] !== 1'b0)
      $display("FAIL clear_prio got bcd=%h run=%b want 0000/0", bcd0, run_o[0]);
    else pass_cnt++;
    rise(2, 2);
    total_cnt++;
    if (bcd0 !== 16'h0000 || run_o[0] !== 1'b0)
      $display("FAIL clear_idle_rise got bcd=%h run=%b want 0000/0", bcd0, run_o[0]);
    else pass_cnt++;
  endtask

  task automatic test_level_reset();
    step(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (20) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (bcd0 !== 16'h0001) $display("FAIL level_once got %h want 0001", bcd0);
    else pass_cnt++;
    run_to(3 * 60 + 25);
    total_cnt++;
    if (bcd0 !== 16'h0325) $display("FAIL midreset_pre got %h want 0325", bcd0);
    else pass_cnt++;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      total_cnt++;
      if (obs_bcd(k) !== 16'h0000 || run_o[k] !== 1'b0 || wrap_o[k] !== 1'b0)
        $display("FAIL midreset dut%0d got bcd=%h run=%b wrap=%b want 0000/0/0", k, obs_bcd(k), run_o[k], wrap_o[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic t;
    t = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) t = ~t;
      step(($urandom_range(0, 499) != 0), t, ($urandom_range(0, 19) == 0), ($urandom_range(0, 99) == 0));
    end
  endtask

  task automatic test_model_agreement();
    for (int k = 0; k < 2; k++) begin
      total_cnt++;
      if (mism[k] !== 0) $display("FAIL cycle_match dut%0d got %0d mismatching cycles want 0", k, mism[k]);
      else pass_cnt++;
    end
    total_cnt++;
    if (wraps_dut[1] !== wraps_ref[1])
      $display("FAIL wrap_count dut1 got %0d want %0d", wraps_dut[1], wraps_ref[1]);
    else pass_cnt++;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_secs[k] = 0; m_presc[k] = 0; m_run[k] = 0; m_wrap[k] = 0;
      mism[k] = 0; wraps_dut[k] = 0; wraps_ref[k] = 0;
    end
    m_tick_prev = 1'b0;
    @(negedge sys_clk);
    test_reset();
    test_start_count();
    test_carry();
    test_rollover();
    test_pause_prescale();
    test_same_cycle();
    test_clear_priority();
    test_level_reset();
    test_random();
    test_model_agreement();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bcd_stopwatch.md
Name: bcd_stopwatch

Overview:
- MM:SS stopwatch counter that consumes the divided clock from the clock divider stage as a count enable, not as a clock.
- The divider output arrives as level signal tick_in, generated synchronously in the sys_clk domain. Each rising edge of tick_in, after prescaling, advances the time by one second.
- Outputs four BCD digits for the downstream seven-segment scan driver, plus status flags.

Parameters:
- TICKS_PER_SEC, 1, tick_in rising edges per one-second increment; legal range 1..1023.
- MIN_WRAP, 60, minutes modulus; 60 gives rollover 59:59 -> 00:00; legal range 1..100.

Ports:
- sys_clk  in  1  system clock; single clock domain.
- sys_rst_n  in  1  synchronous, active-low reset.
- tick_in  in  1  divider output (clk_out), synchronous level signal; only its rising edges are used.
- start_stop  in  1  one-cycle command pulse; toggles run/pause.
- clear  in  1  one-cycle command pulse; returns to zero/idle.
- sec_ones  out  4  BCD seconds units, 0..9.
- sec_tens  out  4  BCD seconds tens, 0..5.
- min_ones  out  4  BCD minutes units, 0..9.
- min_tens  out  4  BCD minutes tens, 0..9.
- running  out  1  high while state == RUN.
- wrap_pulse  out  1  one-cycle pulse on full-scale rollover.

Behaviour:
- Reset: synchronous, active-low, sampled on the sys_clk rising edge. It sets all digits to 0, the prescaler to 0, tick_d to 0, state to IDLE, running to 0 and wrap_pulse to 0. Reset mid-count discards all progress.
- Edge detect: tick_d is the registered copy of tick_in. rise = tick_in & ~tick_d. A tick_in held high counts once only.
- States:
  - IDLE: digits 00:00; start_stop -> RUN.
  - RUN: start_stop -> PAUSE.
  - PAUSE: start_stop -> RUN.
  - clear in any state -> IDLE, with digits and prescaler zeroed.
- Priority: reset > clear > start_stop. clear and start_stop in the same cycle -> IDLE.
- Counting happens only when the current state is RUN and rise = 1:
  - If prescaler == TICKS_PER_SEC-1, the prescaler goes to 0 and the time increments.
  - Otherwise the prescaler increments.
- Same-cycle events:
  - A rise in the cycle where start_stop moves RUN -> PAUSE is still counted.
  - A rise in the cycle where PAUSE -> RUN is not counted.
- PAUSE holds both the digits and the prescaler; a partial second is kept.
- Time increment:
  - sec_ones 9 -> 0 carries into sec_tens.
  - sec_tens 5 with carry -> 0 carries into minutes.
  - min_ones 9 -> 0 carries into min_tens.
  - When minutes == MIN_WRAP-1 and a carry arrives, all four digits go to 0, wrap_pulse = 1 for exactly that cycle, and state stays RUN.
- Latency: digits and wrap_pulse update on the same sys_clk edge that samples tick_in=1 with tick_d=0. They are visible one cycle after tick_in rises.
- All outputs are registered, or decoded from registers only (running). No combinational path runs from the inputs to the outputs.
- Digits never take non-BCD values. sec_tens never exceeds 5.

Decomposition:
- Package stopwatch_pkg:
  - state enum: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2.
  - constants: BCD_MAX=4'd9, SEC_TENS_MAX=4'd5.
  - function giving prescaler width, max($clog2(TICKS_PER_SEC),1).
- Sub-module bcd_digit_cnt, instantiated four times:
  - inputs: clk, sync active-low reset, clr, en, wrap value.
  - outputs: 4-bit digit, carry.
  - carry = en & (digit == wrap value).
- Top level holds the FSM, edge detect, prescaler, minute-rollover compare and wrap_pulse.

Test Plan:
- Reset/start: sys_rst_n low 2 cycles, then high; start_stop pulse; tick_in period 4 sys_clk, TICKS_PER_SEC=1; 12 rises -> digits 00:12, running=1, each update one cycle after the rise.
- Carry chain: run to 00:59, one more rise -> 01:00. Continue to 09:59 -> 10:00, no wrap_pulse.
- Rollover: MIN_WRAP=60, run to 59:59, one rise -> 00:00, wrap_pulse high exactly 1 cycle, running stays 1.
- Pause/prescale: TICKS_PER_SEC=3, 2 rises, pause, 5 rises -> still 00:00. Resume, 1 rise -> 00:01.
- Clear priority: at 00:07 in RUN, assert clear and start_stop in the same cycle -> 00:00, IDLE, running=0. A subsequent rise does not count.
- Level/edge: tick_in held high 20 cycles -> exactly one increment. Mid-count reset at 03:25 -> 00:00, IDLE, next-cycle outputs all 0.
